forwarding_unit: RTL

- Generates the ALU operand forwarding selects and the load-use stall for the 5-stage RV32 core pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of register-address and write-control fields, ID->EX->MEM->WB, and applies the same stall and flush as the datapath.
- The EX-stage operand muxes use its outputs to choose between register-file data, the MEM-stage ALU result and the WB-stage write data.

---
 rtl/forwarding_unit_if.sv | 32 +++
 rtl/forwarding_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/forwarding_unit_if.sv
// Forwarding unit bus: ID-stage decode fields and pipeline control in,
// EX operand selects, load-use stall and shadow rd taps out.
interface forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
) ();
  logic                  stall_i;
  logic                  id_ex_flush_i;
  logic [OPCODE_W-1:0]   opcode_id_i;
  logic [REG_ADDR_W-1:0] rs1_address_id_i;
  logic [REG_ADDR_W-1:0] rs2_address_id_i;
  logic [REG_ADDR_W-1:0] rd_address_id_i;
  logic [1:0]            alu_forward_a_o;
  logic [1:0]            alu_forward_b_o;
  logic                  load_use_stall_o;
  logic [REG_ADDR_W-1:0] rd_address_mem_o;
  logic [REG_ADDR_W-1:0] rd_address_wb_o;

  modport master (
    output stall_i, id_ex_flush_i, opcode_id_i,
           rs1_address_id_i, rs2_address_id_i, rd_address_id_i,
    input  alu_forward_a_o, alu_forward_b_o, load_use_stall_o,
           rd_address_mem_o, rd_address_wb_o
  );

  modport slave (
    input  stall_i, id_ex_flush_i, opcode_id_i,
           rs1_address_id_i, rs2_address_id_i, rd_address_id_i,
    output alu_forward_a_o, alu_forward_b_o, load_use_stall_o,
           rd_address_mem_o, rd_address_wb_o
  );
endinterface

// File: rtl/forwarding_unit.sv
// EX operand forwarding selects and load-use stall for the 5-stage RV32 pipeline,
// driven by a shadow copy of the register-address/write-control fields ID->EX->MEM->WB.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
) (
  input logic          clk,
  input logic          reset,
  forwarding_unit_if.slave fwd
);

  localparam logic [OPCODE_W-1:0] OpBranch = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OpStore  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OpLoad   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OpLui    = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OpAuipc  = OPCODE_W'(7'b0010111);
  localparam logic [OPCODE_W-1:0] OpJal    = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OpRType  = OPCODE_W'(7'b0110011);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  isLoad;
    logic                  usesRs1;
    logic                  usesRs2;
  } exStageT;

  exStageT               idDecode;
  exStageT               exStage_q, exStage_d;
  logic [REG_ADDR_W-1:0] memRd_q, memRd_d;
  logic                  memRegWrite_q, memRegWrite_d;
  logic                  memIsLoad_q, memIsLoad_d;
  logic [REG_ADDR_W-1:0] wbRd_q, wbRd_d;
  logic                  wbRegWrite_q, wbRegWrite_d;
  logic                  loadUseStall;

  always_comb begin
    idDecode          = '0;
    idDecode.rs1      = fwd.rs1_address_id_i;
    idDecode.rs2      = fwd.rs2_address_id_i;
    idDecode.rd       = fwd.rd_address_id_i;
    idDecode.regWrite = !(fwd.opcode_id_i == OpBranch || fwd.opcode_id_i == OpStore ||
                          fwd.opcode_id_i == '0);
    idDecode.isLoad   = (fwd.opcode_id_i == OpLoad);
    idDecode.usesRs1  = !(fwd.opcode_id_i == OpLui || fwd.opcode_id_i == OpAuipc ||
                          fwd.opcode_id_i == OpJal);
    idDecode.usesRs2  = (fwd.opcode_id_i == OpRType || fwd.opcode_id_i == OpBranch ||
                         fwd.opcode_id_i == OpStore);
  end

  // A flush kills the dependent ID instruction, so it overrides the load-use hazard.
  always_comb begin
    loadUseStall = exStage_q.isLoad && exStage_q.regWrite && (exStage_q.rd != '0) &&
                   ((idDecode.usesRs1 && idDecode.rs1 == exStage_q.rd) ||
                    (idDecode.usesRs2 && idDecode.rs2 == exStage_q.rd)) &&
                   !fwd.id_ex_flush_i;
  end

  always_comb begin
    exStage_d     = exStage_q;
    memRd_d       = memRd_q;
    memRegWrite_d = memRegWrite_q;
    memIsLoad_d   = memIsLoad_q;
    wbRd_d        = wbRd_q;
    wbRegWrite_d  = wbRegWrite_q;
    if (!fwd.stall_i) begin
      exStage_d     = (fwd.id_ex_flush_i || loadUseStall) ? '0 : idDecode;
      memRd_d       = exStage_q.rd;
      memRegWrite_d = exStage_q.regWrite;
      memIsLoad_d   = exStage_q.isLoad;
      wbRd_d        = memRd_q;
      wbRegWrite_d  = memRegWrite_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exStage_q     <= '0;
      memRd_q       <= '0;
      memRegWrite_q <= 1'b0;
      memIsLoad_q   <= 1'b0;
      wbRd_q        <= '0;
      wbRegWrite_q  <= 1'b0;
    end else begin
      exStage_q     <= exStage_d;
      memRd_q       <= memRd_d;
      memRegWrite_q <= memRegWrite_d;
      memIsLoad_q   <= memIsLoad_d;
      wbRd_q        <= wbRd_d;
      wbRegWrite_q  <= wbRegWrite_d;
    end
  end

  // MEM has priority over WB so the youngest producer wins.
  always_comb begin
    fwd.alu_forward_a_o = 2'b00;
    fwd.alu_forward_b_o = 2'b00;
    if (exStage_q.usesRs1 && memRegWrite_q && memRd_q != '0 && memRd_q == exStage_q.rs1)
      fwd.alu_forward_a_o = 2'b10;
    else if (exStage_q.usesRs1 && wbRegWrite_q && wbRd_q != '0 && wbRd_q == exStage_q.rs1)
      fwd.alu_forward_a_o = 2'b01;
    if (exStage_q.usesRs2 && memRegWrite_q && memRd_q != '0 && memRd_q == exStage_q.rs2)
      fwd.alu_forward_b_o = 2'b10;
    else if (exStage_q.usesRs2 && wbRegWrite_q && wbRd_q != '0 && wbRd_q == exStage_q.rs2)
      fwd.alu_forward_b_o = 2'b01;
  end

  assign fwd.load_use_stall_o = loadUseStall;
  assign fwd.rd_address_mem_o = memRd_q;
  assign fwd.rd_address_wb_o  = wbRd_q;

  // The load-use stall must keep any consumer out of EX while its load sits in MEM.
  noLoadForwardA: assert property (@(posedge clk) disable iff (reset)
    !(exStage_q.usesRs1 && memIsLoad_q && memRegWrite_q && memRd_q != '0 &&
      memRd_q == exStage_q.rs1));
  noLoadForwardB: assert property (@(posedge clk) disable iff (reset)
    !(exStage_q.usesRs2 && memIsLoad_q && memRegWrite_q && memRd_q != '0 &&
      memRd_q == exStage_q.rs2));

endmodule
